// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared definitions for the data-memory responder: FSM state
//                encoding, RV32 load/store FUNCT3 codes, wait-counter width
//                and the misalignment predicate.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wide enough for LATENCY-1 with LATENCY up to 15.
    localparam int CNT_W = 4;

    // Loads and stores decode size differently: only loads have the unsigned
    // byte/half codes; every unlisted code is a word access.
    function automatic logic is_misaligned(input logic       is_store,
                                           input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic byte_acc;
        logic half_acc;
        byte_acc = is_store ? (funct3 == F3_B) : ((funct3 == F3_B) || (funct3 == F3_BU));
        half_acc = is_store ? (funct3 == F3_H) : ((funct3 == F3_H) || (funct3 == F3_HU));
        if (byte_acc)
            return 1'b0;
        if (half_acc)
            return offset[0];
        return (offset != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Combinational RV32 sub-word alignment.
//                Load path : selects byte/half/word from the stored word and
//                            sign- or zero-extends it.
//                Store path: replicates the store data onto the selected
//                            lanes, merges it over the stored word and
//                            produces the 4-bit byte enable.
//                Half accesses use offset[1] only and word accesses ignore
//                the offset, so misaligned addresses are force-aligned here.
//  Revision    : 1.0 - initial release
//  Ports       : rd_word    in  32  word currently held at the access index
//                wr_data    in  32  right-aligned store data
//                offset     in  2   byte lane (address bits 1:0)
//                funct3     in  3   RV32 load/store size/sign code
//                load_data  out 32  extended load result
//                store_word out 32  word after merging the store
//                byte_en    out 4   lanes written by the store
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wr_data,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic [3:0]  byte_en
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] lane_data;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        case (funct3)
            F3_B: begin
                byte_en   = 4'b0001 << offset;
                lane_data = {4{wr_data[7:0]}};
            end
            F3_H: begin
                byte_en   = offset[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wr_data[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                lane_data = wr_data;
            end
        endcase

        store_word = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i])
                store_word[8*i +: 8] = lane_data[8*i +: 8];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Data-memory end of the MA-stage load/store interface.
//                Accepts a READ/WRITE request, stalls the CPU via BUSYWAIT
//                for LATENCY+1 cycles, commits the access on the last busy
//                edge and presents load data during the following DONE cycle.
//                Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word
//                accesses are suppressed and flagged on ERROR in DONE;
//                without it ERROR is 0 and such accesses are force-aligned.
//  Revision    : 1.0 - initial release
//  Parameters  : ADDR_WIDTH  word-index bits (2**ADDR_WIDTH 32-bit words)
//                LATENCY     wait cycles before commit, 1..15
//  Ports       : CLK        in  1   clock, rising edge
//                RESET      in  1   asynchronous active-high reset
//                READ       in  1   load request
//                WRITE      in  1   store request (wins over READ)
//                FUNCT3     in  3   RV32 access size/sign code
//                ADDRESS    in  32  byte address
//                WRITEDATA  in  32  right-aligned store data
//                READDATA   out 32  registered, extended load result
//                BUSYWAIT   out 1   stall request to the CPU
//                ERROR      out 1   misaligned-access flag
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT,
    output logic        ERROR
);

    // Storage has no reset so that it maps onto block RAM.
    logic [31:0] mem [2**ADDR_WIDTH];

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic [ADDR_WIDTH-1:0]   lat_word;
    logic [1:0]              lat_offset;
    logic [2:0]              lat_funct3;
    logic [31:0]             lat_wdata;
    logic                    lat_store;

    logic [31:0] cur_word;
    logic [31:0] load_data;
    logic [31:0] store_word;
    logic [3:0]  byte_en;
    logic        commit;
    logic        trap;

    // Upper address bits are deliberately ignored so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, ADDRESS[31:ADDR_WIDTH+2]};

    assign cur_word = mem[lat_word];
    assign commit   = (state == ST_WAIT) && (count == '0);

    dmem_lane_align u_align (
        .rd_word    (cur_word),
        .wr_data    (lat_wdata),
        .offset     (lat_offset),
        .funct3     (lat_funct3),
        .load_data  (load_data),
        .store_word (store_word),
        .byte_en    (byte_en)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap = is_misaligned(lat_store, lat_funct3, lat_offset);
`else
    assign trap = 1'b0;
`endif

    // In IDLE the stall must rise in the same cycle the request appears;
    // RESET forces it low even if a request is still being presented.
    assign BUSYWAIT = !RESET &&
                      ((state == ST_IDLE) ? (READ | WRITE) : (state == ST_WAIT));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            count      <= '0;
            READDATA   <= '0;
            lat_word   <= '0;
            lat_offset <= '0;
            lat_funct3 <= '0;
            lat_wdata  <= '0;
            lat_store  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (READ | WRITE) begin
                        lat_word   <= ADDRESS[ADDR_WIDTH+1:2];
                        lat_offset <= ADDRESS[1:0];
                        lat_funct3 <= FUNCT3;
                        lat_wdata  <= WRITEDATA;
                        lat_store  <= WRITE;
                        count      <= CNT_W'(LATENCY - 1);
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        if (!lat_store && !trap)
                            READDATA <= load_data;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Pipeline advances on this edge; a request still visible
                    // now belongs to the instruction that just completed.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic error_q;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            error_q <= 1'b0;
        else if (commit)
            error_q <= trap;
        else
            error_q <= 1'b0;
    end
    assign ERROR = error_q;
`else
    assign ERROR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (commit && lat_store && !trap && !RESET) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem[lat_word][8*i +: 8] <= store_word[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. A byte-addressed
//                reference memory predicts load results, busy windows and
//                the misalignment flag (macro DMEM_MISALIGN_TRAP_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int AW     = 6;
    localparam int LAT    = 2;
    localparam int NBYTES = 4 * (2**AW);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_req;
    logic        wr_req;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .READ      (rd_req),
        .WRITE     (wr_req),
        .FUNCT3    (f3),
        .ADDRESS   (addr),
        .WRITEDATA (wdata),
        .READDATA  (rdata),
        .BUSYWAIT  (busy),
        .ERROR     (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: memory as bytes, plus the last load result.
    logic [7:0]  model_mem [NBYTES];
    logic [31:0] model_rdata;

    function automatic int bidx(input logic [31:0] a);
        return int'(a % 32'(NBYTES));
    endfunction

    function automatic int access_size(input logic st, input logic [2:0] c);
        if (st)
            return (c == 3'b000) ? 1 : (c == 3'b001) ? 2 : 4;
        return (c == 3'b000 || c == 3'b100) ? 1 :
               (c == 3'b001 || c == 3'b101) ? 2 : 4;
    endfunction

    function automatic logic model_trap(input logic st, input logic [2:0] c, input logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
        return (bidx(a) % access_size(st, c)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] c);
        int sz;
        int base;
        logic [31:0] v;
        sz   = access_size(1'b0, c);
        base = bidx(a) - (bidx(a) % sz);
        v    = 32'd0;
        for (int i = 0; i < sz; i++)
            v = v | (32'(model_mem[base + i]) << (8 * i));
        if (c == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (c == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic model_access(input logic w, input logic [2:0] c, input logic [31:0] a,
                                input logic [31:0] d, output logic [31:0] exp_rd,
                                output logic exp_err);
        int sz;
        int base;
        logic [31:0] dd;
        exp_err = model_trap(w, c, a);
        if (!exp_err) begin
            if (w) begin
                sz   = access_size(1'b1, c);
                base = bidx(a) - (bidx(a) % sz);
                dd   = d;
                for (int i = 0; i < sz; i++) begin
                    model_mem[base + i] = dd[7:0];
                    dd = dd >> 8;
                end
            end else begin
                model_rdata = model_load(a, c);
            end
        end
        exp_rd = model_rdata;
    endtask

    // Presents a request starting just after a rising edge and follows it to
    // its DONE cycle; returns one cycle after DONE with inputs still driven.
    task automatic do_access(input logic r, input logic w, input logic [2:0] c,
                             input logic [31:0] a, input logic [31:0] d,
                             output int busy_n, output logic [31:0] rd_done,
                             output logic err_done, output logic err_early);
        rd_req = r; wr_req = w; f3 = c; addr = a; wdata = d;
        busy_n = 0; err_early = 1'b0; rd_done = 'x; err_done = 1'bx;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) begin
                busy_n++;
                if (err) err_early = 1'b1;
            end else begin
                rd_done  = rdata;
                err_done = err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic drop_inputs();
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    task automatic test_reset();
        rd_req = 1'b0; wr_req = 1'b0; f3 = 3'b010; addr = '0; wdata = '0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_readdata got=%h exp=%h", rdata, 32'd0); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busywait got=%b exp=0", busy); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", err); end
        rst = 1'b0;
        model_rdata = 32'd0;
        @(posedge clk); #1;
    endtask

    // Give every word a known value so later loads never read uninitialised RAM.
    task automatic test_fill();
        int bn; logic [31:0] r; logic e, ee, xr; logic [31:0] d;
        for (int i = 0; i < 2**AW; i++) begin
            d = $urandom;
            model_access(1'b1, 3'b010, 32'(i * 4), d, r, xr);
            do_access(1'b0, 1'b1, 3'b010, 32'(i * 4), d, bn, r, e, ee);
            n_tests++; if (bn != LAT + 1) begin n_fail++; $display("FAIL fill_busy idx=%0d got=%0d exp=%0d", i, bn, LAT + 1); end
        end
        drop_inputs();
    endtask

    task automatic test_spec_vectors();
        int bn; logic [31:0] r, xr; logic e, ee, xe;
        logic [31:0] prev;
        logic [31:0] la [4];
        logic [2:0]  lf [4];
        logic [31:0] lx [4];
        la = '{32'h13, 32'h13, 32'h10, 32'h12};
        lf = '{3'b000, 3'b100, 3'b001, 3'b101};
        lx = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_BEEF, 32'h0000_DEAD};

        prev = model_rdata;
        model_access(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, xr, xe);
        do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, bn, r, e, ee);
        drop_inputs();
        n_tests++; if (bn != 3) begin n_fail++; $display("FAIL sw_busy_window got=%0d exp=3", bn); end
        n_tests++; if (r !== prev) begin n_fail++; $display("FAIL sw_keeps_readdata got=%h exp=%h", r, prev); end
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_done got=%b exp=0", busy); end
        @(posedge clk); #1;

        model_access(1'b0, 3'b010, 32'h10, 32'h0, xr, xe);
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, bn, r, e, ee);
        n_tests++; if (bn != 3) begin n_fail++; $display("FAIL lw_busy_window got=%0d exp=3", bn); end
        n_tests++; if (r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_10 got=%h exp=%h", r, 32'hDEAD_BEEF); end

        for (int i = 0; i < 4; i++) begin
            model_access(1'b0, lf[i], la[i], 32'h0, xr, xe);
            do_access(1'b1, 1'b0, lf[i], la[i], 32'h0, bn, r, e, ee);
            n_tests++; if (r !== lx[i]) begin n_fail++; $display("FAIL subword_load f3=%b addr=%h got=%h exp=%h", lf[i], la[i], r, lx[i]); end
        end

        model_access(1'b1, 3'b000, 32'h11, 32'h55, xr, xe);
        do_access(1'b0, 1'b1, 3'b000, 32'h11, 32'h0000_0055, bn, r, e, ee);
        model_access(1'b0, 3'b010, 32'h10, 32'h0, xr, xe);
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, bn, r, e, ee);
        n_tests++; if (r !== 32'hDEAD_55EF) begin n_fail++; $display("FAIL sb_merge got=%h exp=%h", r, 32'hDEAD_55EF); end

        model_access(1'b1, 3'b001, 32'h12, 32'h1234, xr, xe);
        do_access(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000_1234, bn, r, e, ee);
        model_access(1'b0, 3'b010, 32'h10, 32'h0, xr, xe);
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, bn, r, e, ee);
        n_tests++; if (r !== 32'h1234_55EF) begin n_fail++; $display("FAIL sh_merge got=%h exp=%h", r, 32'h1234_55EF); end
        drop_inputs();
    endtask

    task automatic test_back_to_back();
        int bn; logic [31:0] r, xr; logic e, ee, xe;
        logic [31:0] d1, d2;
        d1 = $urandom; d2 = $urandom;
        // LW held through its DONE cycle, SW presented right after.
        model_access(1'b0, 3'b010, 32'h10, 32'h0, xr, xe);
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, bn, r, e, ee);
        model_access(1'b1, 3'b010, 32'h14, d1, xr, xe);
        do_access(1'b0, 1'b1, 3'b010, 32'h14, d1, bn, r, e, ee);
        n_tests++; if (bn != LAT + 1) begin n_fail++; $display("FAIL b2b_second_busy got=%0d exp=%0d", bn, LAT + 1); end
        n_tests++; if (r !== 32'h1234_55EF) begin n_fail++; $display("FAIL b2b_readdata_hold got=%h exp=%h", r, 32'h1234_55EF); end
        model_access(1'b0, 3'b010, 32'h14, 32'h0, xr, xe);
        do_access(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, bn, r, e, ee);
        n_tests++; if (r !== d1) begin n_fail++; $display("FAIL b2b_store_landed got=%h exp=%h", r, d1); end

        // Both strobes set: a store.
        model_access(1'b1, 3'b010, 32'h18, d2, xr, xe);
        do_access(1'b1, 1'b1, 3'b010, 32'h18, d2, bn, r, e, ee);
        n_tests++; if (r !== d1) begin n_fail++; $display("FAIL rw_is_store_readdata got=%h exp=%h", r, d1); end
        model_access(1'b0, 3'b010, 32'h18, 32'h0, xr, xe);
        do_access(1'b1, 1'b0, 3'b010, 32'h18, 32'h0, bn, r, e, ee);
        n_tests++; if (r !== d2) begin n_fail++; $display("FAIL rw_is_store_mem got=%h exp=%h", r, d2); end
        drop_inputs();
    endtask

    task automatic test_reset_mid();
        int bn; logic [31:0] r, xr; logic e, ee, xe;
        model_access(1'b1, 3'b010, 32'h20, 32'h0, xr, xe);
        do_access(1'b0, 1'b1, 3'b010, 32'h20, 32'h0, bn, r, e, ee);
        model_access(1'b0, 3'b010, 32'h10, 32'h0, xr, xe);
        do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, bn, r, e, ee);
        drop_inputs();
        @(posedge clk); #1;
        rd_req = 1'b0; wr_req = 1'b1; f3 = 3'b010; addr = 32'h20; wdata = 32'hAAAA_AAAA;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before_reset got=%b exp=1", busy); end
        rst = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL mid_reset_readdata got=%h exp=0", rdata); end
        @(posedge clk); #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_held_busy got=%b exp=0", busy); end
        drop_inputs();
        @(negedge clk);
        rst = 1'b0;
        model_rdata = 32'd0;
        @(posedge clk); #1;
        model_access(1'b0, 3'b010, 32'h20, 32'h0, xr, xe);
        do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, bn, r, e, ee);
        n_tests++; if (r !== 32'd0) begin n_fail++; $display("FAIL mid_reset_store_discarded got=%h exp=0", r); end
        n_tests++; if (bn != LAT + 1) begin n_fail++; $display("FAIL post_reset_busy got=%0d exp=%0d", bn, LAT + 1); end
        drop_inputs();
    endtask

    task automatic test_random();
        int bn; logic [31:0] r, xr; logic e, ee, xe;
        logic rr, ww; logic [2:0] c; logic [31:0] a, d; int op;
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 2);
            rr = (op != 1); ww = (op != 0);
            c = 3'($urandom); a = $urandom; d = $urandom;
            model_access(ww, c, a, d, xr, xe);
            do_access(rr, ww, c, a, d, bn, r, e, ee);
            n_tests++; if (bn != LAT + 1) begin n_fail++; $display("FAIL rand_busy i=%0d got=%0d exp=%0d", i, bn, LAT + 1); end
            n_tests++; if (r !== xr) begin n_fail++; $display("FAIL rand_data i=%0d op=%0d f3=%b addr=%h got=%h exp=%h", i, op, c, a, r, xr); end
            n_tests++; if (e !== xe) begin n_fail++; $display("FAIL rand_error i=%0d got=%b exp=%b", i, e, xe); end
            n_tests++; if (ee !== 1'b0) begin n_fail++; $display("FAIL rand_error_early i=%0d got=%b exp=0", i, ee); end
            if ($urandom_range(0, 3) == 0) begin
                drop_inputs();
                @(negedge clk);
                n_tests++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rand_idle busy=%b err=%b exp=0/0", busy, err); end
                @(posedge clk); #1;
            end
        end
        drop_inputs();
    endtask

    task automatic test_misalign();
        int bn; logic [31:0] r, xr, prev, w20; logic e, ee, xe;
        model_access(1'b0, 3'b000, 32'h13, 32'h0, xr, xe);
        do_access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, bn, r, e, ee);
        prev = model_rdata;
        w20  = model_load(32'h20, 3'b010);
`ifdef DMEM_MISALIGN_TRAP_EN
        do_access(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, bn, r, e, ee);
        drop_inputs();
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL trap_lw_error got=%b exp=1", e); end
        n_tests++; if (ee !== 1'b0) begin n_fail++; $display("FAIL trap_lw_error_early got=%b exp=0", ee); end
        n_tests++; if (r !== prev) begin n_fail++; $display("FAIL trap_lw_readdata got=%h exp=%h", r, prev); end
        @(negedge clk);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL trap_error_after_done got=%b exp=0", err); end
        @(posedge clk); #1;
        do_access(1'b0, 1'b1, 3'b010, 32'h21, 32'h5A5A_5A5A, bn, r, e, ee);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL trap_sw_error got=%b exp=1", e); end
        do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, bn, r, e, ee);
        n_tests++; if (r !== w20) begin n_fail++; $display("FAIL trap_sw_mem_unchanged got=%h exp=%h", r, w20); end
        model_rdata = w20;
`else
        do_access(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, bn, r, e, ee);
        n_tests++; if (r !== w20) begin n_fail++; $display("FAIL align_lw_22 got=%h exp=%h prev=%h", r, w20, prev); end
        n_tests++; if (e !== 1'b0 || ee !== 1'b0) begin n_fail++; $display("FAIL align_error got=%b/%b exp=0/0", e, ee); end
        model_rdata = w20;
`endif
        drop_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_spec_vectors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
